// File: rtl/cache_l1d_pkg.sv
// ============================================================================
//  cache_l1d_pkg : shared constants, FSM state codes and load/store encodings
//  for the L1 data-cache controller.   Revision: 1.0
// ============================================================================
`default_nettype none

package cache_l1d_pkg;

    localparam int DEF_TAG_SIZE       = 9;
    localparam int DEF_IDX_SIZE       = 6;
    localparam int DEF_WORD_SIZE      = 2;
    localparam int DEF_OFFSET_SIZE    = 2;
    localparam int DEF_BLOCK_SIZE     = 128;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DATA_W             = 64;
    localparam int INSTR_W            = 3;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE         = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOOKUP       = 3'd1;
    localparam logic [STATE_W-1:0] ST_STORE        = 3'd2;
    localparam logic [STATE_W-1:0] ST_WT_SEND      = 3'd3;
    localparam logic [STATE_W-1:0] ST_REFILL_REQ   = 3'd4;
    localparam logic [STATE_W-1:0] ST_REFILL_WRITE = 3'd5;
    localparam logic [STATE_W-1:0] ST_RESP         = 3'd6;
    localparam logic [STATE_W-1:0] ST_ERR          = 3'd7;

    typedef enum logic [INSTR_W-1:0] {
        LD_LB  = 3'd0,
        LD_LH  = 3'd1,
        LD_LW  = 3'd2,
        LD_LD  = 3'd3,
        LD_LBU = 3'd4,
        LD_LHU = 3'd5,
        LD_LWU = 3'd6
    } load_instr_e;

    typedef enum logic [INSTR_W-1:0] {
        ST_SB = 3'd0,
        ST_SH = 3'd1,
        ST_SW = 3'd2,
        ST_SD = 3'd3
    } store_instr_e;

endpackage

`default_nettype wire

// File: rtl/cache_l1d_timeout.sv
// ============================================================================
//  cache_l1d_timeout : counts refill cycles without an L2 acknowledge and
//  flags the cycle in which the limit is reached.   Revision: 1.0
// ============================================================================
`default_nettype none

module cache_l1d_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expiry is the cycle whose un-acked increment makes the count reach the limit.
    assign expired_o = enable_i && !clear_i && (cnt_q == LIMIT_M1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_ctrl_l1_data.sv
// ============================================================================
//  cache_ctrl_l1_data : L1 data-cache controller (lookup, write-through,
//  L2 refill with timeout). Build option: L1D_WRITE_ALLOCATE_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module cache_ctrl_l1_data
    import cache_l1d_pkg::*;
#(
    parameter int TAG_SIZE       = DEF_TAG_SIZE,
    parameter int IDX_SIZE       = DEF_IDX_SIZE,
    parameter int WORD_SIZE      = DEF_WORD_SIZE,
    parameter int OFFSET_SIZE    = DEF_OFFSET_SIZE,
    parameter int BLOCK_SIZE     = DEF_BLOCK_SIZE,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int AW             = TAG_SIZE + IDX_SIZE + WORD_SIZE + OFFSET_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [INSTR_W-1:0]    req_read_instr_i,
    input  logic [INSTR_W-1:0]    req_write_instr_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DATA_W-1:0]     req_data_i,
    output logic                  resp_valid_o,
    output logic [DATA_W-1:0]     resp_data_o,
    output logic                  resp_err_o,
    output logic                  cache_read_o,
    output logic                  cache_write_o,
    output logic                  cache_write_l2_o,
    output logic                  cache_write_through_o,
    output logic [AW-1:0]         cache_addr_o,
    output logic [DATA_W-1:0]     cache_data_o,
    output logic [BLOCK_SIZE-1:0] cache_block_o,
    output logic [INSTR_W-1:0]    cache_instr_o,
    input  logic                  cache_hit_i,
    input  logic [DATA_W-1:0]     cache_data_i,
    output logic                  l2_req_o,
    output logic [AW-1:0]         l2_addr_o,
    input  logic                  l2_ack_i,
    input  logic [BLOCK_SIZE-1:0] l2_data_i,
    output logic                  wt_valid_o,
    input  logic                  wt_ready_i,
    output logic [AW-1:0]         wt_addr_o,
    output logic [DATA_W-1:0]     wt_data_o,
    output logic [INSTR_W-1:0]    wt_instr_o
);

    localparam int LOW_W = WORD_SIZE + OFFSET_SIZE;

    logic [STATE_W-1:0]    state_q, state_d;
    logic                  we_q, we_d;
    logic [INSTR_W-1:0]    rinstr_q, rinstr_d;
    logic [INSTR_W-1:0]    winstr_q, winstr_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DATA_W-1:0]     resp_data_q, resp_data_d;
    logic [BLOCK_SIZE-1:0] blk_q, blk_d;

    logic to_clear;
    logic to_enable;
    logic to_expired;

    assign to_clear  = (state_q != ST_REFILL_REQ);
    assign to_enable = (state_q == ST_REFILL_REQ) && !l2_ack_i;

    cache_l1d_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (to_clear),
        .enable_i  (to_enable),
        .expired_o (to_expired)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        rinstr_d    = rinstr_q;
        winstr_d    = winstr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        resp_data_d = resp_data_q;
        blk_d       = blk_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d        = req_we_i;
                    rinstr_d    = req_read_instr_i;
                    winstr_d    = req_write_instr_i;
                    addr_d      = req_addr_i;
                    data_d      = req_data_i;
                    resp_data_d = '0;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (cache_hit_i) begin
                    if (we_q) begin
                        state_d = ST_STORE;
                    end else begin
                        resp_data_d = cache_data_i;
                        state_d     = ST_RESP;
                    end
                end else if (we_q) begin
`ifdef L1D_WRITE_ALLOCATE_EN
                    state_d = ST_REFILL_REQ;
`else
                    state_d = ST_WT_SEND;
`endif
                end else begin
                    state_d = ST_REFILL_REQ;
                end
            end
            ST_STORE: state_d = ST_WT_SEND;
            ST_WT_SEND: begin
                if (wt_ready_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_REFILL_REQ: begin
                // An ack in the limit cycle takes priority over expiry.
                if (l2_ack_i) begin
                    blk_d   = l2_data_i;
                    state_d = ST_REFILL_WRITE;
                end else if (to_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_REFILL_WRITE: state_d = ST_LOOKUP;
            ST_RESP:         state_d = ST_IDLE;
            ST_ERR:          state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            rinstr_q    <= '0;
            winstr_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            resp_data_q <= '0;
            blk_q       <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            rinstr_q    <= rinstr_d;
            winstr_q    <= winstr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            resp_data_q <= resp_data_d;
            blk_q       <= blk_d;
        end
    end

    // Outputs are forced low while reset is held, even before state has cleared.
    always_comb begin
        req_ready_o           = 1'b0;
        resp_valid_o          = 1'b0;
        resp_data_o           = '0;
        resp_err_o            = 1'b0;
        cache_read_o          = 1'b0;
        cache_write_o         = 1'b0;
        cache_write_l2_o      = 1'b0;
        cache_write_through_o = 1'b0;
        cache_addr_o          = '0;
        cache_data_o          = '0;
        cache_block_o         = '0;
        cache_instr_o         = '0;
        l2_req_o              = 1'b0;
        l2_addr_o             = '0;
        wt_valid_o            = 1'b0;
        wt_addr_o             = '0;
        wt_data_o             = '0;
        wt_instr_o            = '0;
        if (!rst_i) begin
            cache_addr_o  = addr_q;
            cache_data_o  = data_q;
            cache_instr_o = we_q ? winstr_q : rinstr_q;
            l2_addr_o     = {addr_q[AW-1:LOW_W], {LOW_W{1'b0}}};
            wt_addr_o     = addr_q;
            wt_data_o     = data_q;
            wt_instr_o    = winstr_q;
            case (state_q)
                ST_IDLE:   req_ready_o = 1'b1;
                ST_LOOKUP: cache_read_o = 1'b1;
                ST_STORE: begin
                    cache_write_o         = 1'b1;
                    cache_write_through_o = 1'b1;
                end
                ST_WT_SEND:    wt_valid_o = 1'b1;
                ST_REFILL_REQ: l2_req_o = 1'b1;
                ST_REFILL_WRITE: begin
                    cache_write_l2_o = 1'b1;
                    cache_block_o    = blk_q;
                end
                ST_RESP: begin
                    resp_valid_o = 1'b1;
                    resp_data_o  = resp_data_q;
                end
                ST_ERR: begin
                    resp_valid_o = 1'b1;
                    resp_err_o   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl_l1_data.sv
// ============================================================================
//  tb_cache_ctrl_l1_data : directed + randomized checks of the L1D controller
//  against a transaction-level latency/behaviour model.   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cache_ctrl_l1_data;

    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [2:0]    req_read_instr_i;
    logic [2:0]    req_write_instr_i;
    logic [18:0]   req_addr_i;
    logic [63:0]   req_data_i;
    logic          resp_valid_o;
    logic [63:0]   resp_data_o;
    logic          resp_err_o;
    logic          cache_read_o, cache_write_o, cache_write_l2_o, cache_write_through_o;
    logic [18:0]   cache_addr_o;
    logic [63:0]   cache_data_o;
    logic [127:0]  cache_block_o;
    logic [2:0]    cache_instr_o;
    logic          cache_hit_i;
    logic [63:0]   cache_data_i;
    logic          l2_req_o;
    logic [18:0]   l2_addr_o;
    logic          l2_ack_i;
    logic [127:0]  l2_data_i;
    logic          wt_valid_o;
    logic          wt_ready_i;
    logic [18:0]   wt_addr_o;
    logic [63:0]   wt_data_o;
    logic [2:0]    wt_instr_o;

    int checks = 0;
    int failures = 0;

    // Environment: L2 / write-through responders and a simple cache array.
    int           ack_delay = 0;
    int           wt_delay = 0;
    int           l2_cnt = 0;
    int           wt_cnt = 0;
    bit           spur_ack = 0;
    bit           spur_wt = 0;
    logic [127:0] refill_blk = '0;
    logic [63:0]  cur_data = '0;
    bit           env_vld [64];
    logic [8:0]   env_tag [64];
    logic [127:0] env_blk [64];
    logic [5:0]   c_idx;
    logic [1:0]   c_word;

    always #5 clk = ~clk;

    cache_ctrl_l1_data dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .req_valid_i           (req_valid_i),
        .req_ready_o           (req_ready_o),
        .req_we_i              (req_we_i),
        .req_read_instr_i      (req_read_instr_i),
        .req_write_instr_i     (req_write_instr_i),
        .req_addr_i            (req_addr_i),
        .req_data_i            (req_data_i),
        .resp_valid_o          (resp_valid_o),
        .resp_data_o           (resp_data_o),
        .resp_err_o            (resp_err_o),
        .cache_read_o          (cache_read_o),
        .cache_write_o         (cache_write_o),
        .cache_write_l2_o      (cache_write_l2_o),
        .cache_write_through_o (cache_write_through_o),
        .cache_addr_o          (cache_addr_o),
        .cache_data_o          (cache_data_o),
        .cache_block_o         (cache_block_o),
        .cache_instr_o         (cache_instr_o),
        .cache_hit_i           (cache_hit_i),
        .cache_data_i          (cache_data_i),
        .l2_req_o              (l2_req_o),
        .l2_addr_o             (l2_addr_o),
        .l2_ack_i              (l2_ack_i),
        .l2_data_i             (l2_data_i),
        .wt_valid_o            (wt_valid_o),
        .wt_ready_i            (wt_ready_i),
        .wt_addr_o             (wt_addr_o),
        .wt_data_o             (wt_data_o),
        .wt_instr_o            (wt_instr_o)
    );

    assign c_idx        = cache_addr_o[9:4];
    assign c_word       = cache_addr_o[3:2];
    assign cache_hit_i  = cache_read_o && env_vld[c_idx] && (env_tag[c_idx] == cache_addr_o[18:10]);
    assign cache_data_i = {32'h0, env_blk[c_idx][int'(c_word)*32 +: 32]};
    assign l2_ack_i     = (l2_req_o && (l2_cnt == ack_delay)) || spur_ack;
    assign l2_data_i    = refill_blk;
    assign wt_ready_i   = (wt_valid_o && (wt_cnt == wt_delay)) || spur_wt;

    always @(posedge clk) begin
        l2_cnt <= l2_req_o ? l2_cnt + 1 : 0;
        wt_cnt <= wt_valid_o ? wt_cnt + 1 : 0;
        if (cache_write_l2_o) begin
            env_vld[c_idx] <= 1'b1;
            env_tag[c_idx] <= cache_addr_o[18:10];
            env_blk[c_idx] <= refill_blk;
        end
        if (cache_write_o) begin
            env_blk[c_idx][int'(c_word)*32 +: 32] <= cur_data[31:0];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request, checked against a latency/count model derived from the state sequence.
    task automatic txn(input bit we, input logic [18:0] addr, input logic [63:0] data,
                       input int ackd, input int wtd, input string nm);
        int idx, w, lat, exp_l2, exp_wt, k, cw, wl2, l2c, wtc;
        bit hit, alloc, refill, err, exp_wl2, exp_cw, got, rerr, bad;
        logic [63:0] exp_data, rdata;
        logic [2:0]  rin, win;
        idx  = int'(addr[9:4]);
        w    = int'(addr[3:2]);
        hit  = env_vld[idx] && (env_tag[idx] == addr[18:10]);
        alloc = 1'b0;
`ifdef L1D_WRITE_ALLOCATE_EN
        alloc = 1'b1;
`endif
        refill  = !hit && (!we || alloc);
        err     = refill && (ackd >= TO);
        exp_l2  = refill ? (err ? TO : ackd + 1) : 0;
        exp_wl2 = refill && !err;
        exp_cw  = we && !err && (hit || alloc);
        exp_wt  = (we && !err) ? wtd + 1 : 0;
        lat = 1 + exp_l2;
        if (err) lat += 1;
        else begin
            if (refill) lat += 2;
            if (exp_cw) lat += 1;
            lat += exp_wt + 1;
        end
        if (err)      exp_data = '0;
        else if (hit) exp_data = {32'h0, env_blk[idx][w*32 +: 32]};
        else          exp_data = {32'h0, refill_blk[w*32 +: 32]};
        rin = 3'($urandom_range(0, 6));
        win = 3'($urandom_range(0, 3));
        cur_data  = data;
        ack_delay = ackd;
        wt_delay  = wtd;
        spur_ack  = !we && hit;
        spur_wt   = !we && hit;
        chk({nm, ".ready"}, 128'(req_ready_o), 128'd1);
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_data_i = data;
        req_read_instr_i = rin; req_write_instr_i = win;
        @(posedge clk); #1;
        req_valid_i = 1'b0; req_addr_i = ~addr; req_data_i = ~data;
        k = 0; got = 0; cw = 0; wl2 = 0; l2c = 0; wtc = 0; bad = 0; rerr = 0; rdata = '0;
        while (!got && k < 400) begin
            @(negedge clk); k++;
            if (cache_write_o) begin
                cw++;
                bad |= (cache_addr_o !== addr) || (cache_data_o !== data) ||
                       (cache_instr_o !== win) || !cache_write_through_o;
            end
            if (cache_write_l2_o) begin
                wl2++;
                bad |= (cache_block_o !== refill_blk) || (cache_addr_o !== addr);
            end
            if (l2_req_o) begin
                l2c++;
                bad |= (l2_addr_o !== {addr[18:4], 4'h0});
            end
            if (wt_valid_o) begin
                wtc++;
                bad |= (wt_addr_o !== addr) || (wt_data_o !== data) || (wt_instr_o !== win);
            end
            if (resp_valid_o) begin
                got = 1; rerr = resp_err_o; rdata = resp_data_o;
            end
        end
        chk({nm, ".latency"}, 128'(k), 128'(lat));
        chk({nm, ".err"}, 128'(rerr), 128'(err));
        if (!we || err) chk({nm, ".data"}, 128'(rdata), 128'(exp_data));
        chk({nm, ".l2_cycles"}, 128'(l2c), 128'(exp_l2));
        chk({nm, ".wr_l2"}, 128'(wl2), 128'(exp_wl2));
        chk({nm, ".cache_wr"}, 128'(cw), 128'(exp_cw));
        chk({nm, ".wt_cycles"}, 128'(wtc), 128'(exp_wt));
        chk({nm, ".fields"}, 128'(bad), 128'd0);
        spur_ack = 0; spur_wt = 0;
        @(negedge clk);
        chk({nm, ".back_idle"}, 128'({req_ready_o, resp_valid_o}), 128'b10);
    endtask

    initial begin
        int k;
        bit seen;
        rst_i = 1'b1; req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_data_i = '0;
        req_read_instr_i = '0; req_write_instr_i = '0;
        repeat (2) @(negedge clk);
        chk("reset.ctrl", 128'({req_ready_o, resp_valid_o, resp_err_o, cache_read_o, cache_write_o,
                                 cache_write_l2_o, cache_write_through_o, l2_req_o, wt_valid_o}), 128'd0);
        chk("reset.data", 128'({resp_data_o, cache_addr_o, l2_addr_o, wt_addr_o}), 128'd0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset.ready_after", 128'(req_ready_o), 128'd1);

        // Directed: miss with A5 block, store hit with stalled write-through, load hit.
        refill_blk = {4{32'hA5A5_A5A5}};
        txn(1'b0, 19'h1234A, 64'h0, 3, 0, "load_miss");
        txn(1'b1, 19'h1234A, 64'h0000_0000_DEAD_BEEF, 0, 4, "store_hit");
        txn(1'b0, 19'h1234A, 64'h0, 0, 0, "load_hit");
        txn(1'b1, 19'h2F0F4, 64'h1111_2222_3333_4444, 2, 1, "store_miss");
        txn(1'b0, 19'h2F0F4, 64'h0, 1, 0, "load_after_store_miss");
        refill_blk = {$urandom, $urandom, $urandom, $urandom};
        txn(1'b0, 19'h05550, 64'h0, 1000, 0, "timeout");
        txn(1'b0, 19'h05554, 64'h0, TO - 1, 0, "ack_at_limit");

        for (int i = 0; i < 40; i++) begin
            logic [18:0] a;
            a = {9'(9'h40 + 9'($urandom_range(0, 1))), 6'(6'd8 + 6'($urandom_range(0, 3))),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            refill_blk = {$urandom, $urandom, $urandom, $urandom};
            txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                $urandom_range(0, 5), $urandom_range(0, 4), "rand");
        end

        // Reset while waiting on L2 must silently abandon the request.
        ack_delay = 1000;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 19'h7ABC8;
        @(posedge clk); #1; req_valid_i = 1'b0;
        k = 0; seen = 0;
        while (!l2_req_o && k < 10) begin @(negedge clk); k++; end
        chk("rst_mid.l2_req_seen", 128'(l2_req_o), 128'd1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_mid.l2_req_dropped", 128'({l2_req_o, resp_valid_o, req_ready_o}), 128'd0);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen |= resp_valid_o;
        end
        chk("rst_mid.no_resp", 128'(seen), 128'd0);
        chk("rst_mid.ready", 128'(req_ready_o), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
